servant_fram_arbiter: RTL

Arbitrates one byte-wide, single-port external SRAM (the FRAM-emulation backing store) between two requesters. Port A is the SPI-side bridge (synchronised into i_clk) and port B is the servant core/debug bus. Each request runs through a fixed SETUP/STROBE/HOLD timing sequence on the SRAM pins. Concurrent requests are resolved round-robin.

---
 rtl/servant_fram_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/servant_fram_arbiter.sv
// servant_fram_arbiter
// Two-port round-robin arbiter in front of a byte-wide single-port SRAM.
// Every access runs SETUP -> STROBE (WAIT_CYCLES+1) -> HOLD on the SRAM pins.
// All outputs come straight from registers.
module servant_fram_arbiter #(
  parameter int ADDRESS_WIDTH = 18,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_a_stb,
  input  logic                     i_a_we,
  input  logic [ADDRESS_WIDTH-1:0] i_a_adr,
  input  logic [7:0]               i_a_dat,
  output logic                     o_a_ack,
  output logic [7:0]               o_a_rdt,
  input  logic                     i_b_stb,
  input  logic                     i_b_we,
  input  logic [ADDRESS_WIDTH-1:0] i_b_adr,
  input  logic [7:0]               i_b_dat,
  output logic                     o_b_ack,
  output logic [7:0]               o_b_rdt,
  output logic [ADDRESS_WIDTH-1:0] o_sram_addr,
  output logic                     o_sram_csn,
  output logic                     o_sram_oen,
  output logic                     o_sram_wen,
  output logic                     o_sram_dq_oe,
  output logic [7:0]               o_sram_dq_out,
  input  logic [7:0]               i_sram_dq_in,
  output logic                     o_busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam int             CW          = $clog2(WAIT_CYCLES + 1) + 1;
  localparam logic [CW-1:0]  LAST_STROBE = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0]  CNT_ZERO    = CW'(0);
  localparam logic [CW-1:0]  CNT_ONE     = CW'(1);

  logic [1:0]               r_state;
  logic [CW-1:0]            r_cnt;
  logic                     r_we;
  logic                     r_port_b;
  logic                     r_prio_a;   // 1: port A wins the next tie
  logic                     r_a_ack;
  logic                     r_b_ack;
  logic [7:0]               r_a_rdt;
  logic [7:0]               r_b_rdt;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic                     r_csn;
  logic                     r_oen;
  logic                     r_wen;
  logic                     r_dq_oe;
  logic [7:0]               r_dq_out;
  logic                     r_busy;

  // Grant decision: a lone requester always wins, a tie goes to r_prio_a.
  logic                     w_grant_a;
  logic                     w_grant_b;
  logic                     w_sel_we;
  logic [ADDRESS_WIDTH-1:0] w_sel_adr;
  logic [7:0]               w_sel_dat;

  assign w_grant_a = i_a_stb & (~i_b_stb | r_prio_a);
  assign w_grant_b = i_b_stb & ~w_grant_a;
  assign w_sel_we  = w_grant_a ? i_a_we  : i_b_we;
  assign w_sel_adr = w_grant_a ? i_a_adr : i_b_adr;
  assign w_sel_dat = w_grant_a ? i_a_dat : i_b_dat;

  // Access sequencer: state, SRAM pin registers, acks and read-data capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= CNT_ZERO;
      r_we     <= 1'b0;
      r_port_b <= 1'b0;
      r_prio_a <= 1'b1;
      r_a_ack  <= 1'b0;
      r_b_ack  <= 1'b0;
      r_a_rdt  <= 8'h00;
      r_b_rdt  <= 8'h00;
      r_addr   <= '0;
      r_csn    <= 1'b1;
      r_oen    <= 1'b1;
      r_wen    <= 1'b1;
      r_dq_oe  <= 1'b0;
      r_dq_out <= 8'h00;
      r_busy   <= 1'b0;
    end else begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_a | w_grant_b) begin
            r_state  <= S_SETUP;
            r_busy   <= 1'b1;
            r_we     <= w_sel_we;
            r_port_b <= w_grant_b;
            r_prio_a <= w_grant_b;
            r_csn    <= 1'b0;
            r_addr   <= w_sel_adr;
            r_dq_oe  <= w_sel_we;
            r_dq_out <= w_sel_we ? w_sel_dat : 8'h00;
          end
        end
        S_SETUP: begin
          r_state <= S_STROBE;
          r_cnt   <= CNT_ZERO;
          r_oen   <= r_we;
          r_wen   <= ~r_we;
        end
        S_STROBE: begin
          if (r_cnt == LAST_STROBE) begin
            r_state <= S_HOLD;
            r_oen   <= 1'b1;
            r_wen   <= 1'b1;
            r_a_ack <= ~r_port_b;
            r_b_ack <= r_port_b;
            if (!r_we && !r_port_b) r_a_rdt <= i_sram_dq_in;
            if (!r_we &&  r_port_b) r_b_rdt <= i_sram_dq_in;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_HOLD: begin
          r_state <= S_IDLE;
          r_csn   <= 1'b1;
          r_dq_oe <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_csn   <= 1'b1;
          r_oen   <= 1'b1;
          r_wen   <= 1'b1;
          r_dq_oe <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_a_ack       = r_a_ack;
  assign o_b_ack       = r_b_ack;
  assign o_a_rdt       = r_a_rdt;
  assign o_b_rdt       = r_b_rdt;
  assign o_sram_addr   = r_addr;
  assign o_sram_csn    = r_csn;
  assign o_sram_oen    = r_oen;
  assign o_sram_wen    = r_wen;
  assign o_sram_dq_oe  = r_dq_oe;
  assign o_sram_dq_out = r_dq_out;
  assign o_busy        = r_busy;

endmodule
